alu_req_arbiter: RTL and testbench

- Shares one combinational 16-bit ALU between two requesters (port 0 and port 1) using valid/ready handshakes.
- Sequences each operation through issue, capture and response, and returns the result, the flags and the requester ID.
- Holds the architectural flag register: F, C updated on ADD/SUB; L, N, Z updated on CMP.
- Sits between instruction-issue logic and the ALU instance; drives the ALU inputs and samples the ALU outputs.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_rr_grant.sv | 46 ++++
 rtl/alu_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcodes, flag indices and FSM state type for the ALU request arbiter.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 6;
  localparam int FLAG_W = 5;

  localparam logic [SEL_W-1:0] OP_ADD = 6'b100000;
  localparam logic [SEL_W-1:0] OP_SUB = 6'b010000;
  localparam logic [SEL_W-1:0] OP_CMP = 6'b001000;
  localparam logic [SEL_W-1:0] OP_AND = 6'b000100;
  localparam logic [SEL_W-1:0] OP_OR  = 6'b000010;
  localparam logic [SEL_W-1:0] OP_XOR = 6'b000001;

  localparam int FLG_F = 4;
  localparam int FLG_L = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // A select is legal only when exactly one bit is set.
  function automatic logic sel_is_onehot(input logic [SEL_W-1:0] sel);
    logic [SEL_W-1:0] one;
    one = {{(SEL_W-1){1'b0}}, 1'b1};
    return (sel != '0) && ((sel & (sel - one)) == '0);
  endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// Two-way grant for the ALU arbiter. Round-robin pointer by default;
// with ALU_ARB_FIXED_PRIO_EN defined, port 0 always wins and no pointer exists.
module alu_rr_grant (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic v0,
  input  logic v1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  assign gnt0 = en & v0;
  assign gnt1 = en & v1 & ~v0;

`else

  logic rr_q;
  logic rr_d;

  // rr_q names the port preferred when both request together.
  assign gnt0 = en & v0 & (~v1 | ~rr_q);
  assign gnt1 = en & v1 & (~v0 | rr_q);

  always_comb begin
    rr_d = rr_q;
    if (en && v0 && v1) begin
      rr_d = gnt0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and owns the flag register.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module alu_req_arbiter
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flcnz,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [FLAG_W-1:0] flags
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic grant_en;
  logic gnt0;
  logic gnt1;

  assign grant_en = (state_q == ST_IDLE);

  alu_rr_grant u_grant (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk  (CLK),
    .rst  (RESET),
`endif
    .en   (grant_en),
    .v0   (req0_valid),
    .v1   (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign flags     = flags_q;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    flags_d     = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          alu_a_d   = gnt1 ? req1_a   : req0_a;
          alu_b_d   = gnt1 ? req1_b   : req0_b;
          alu_sel_d = gnt1 ? req1_sel : req0_sel;
          id_d      = gnt1;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = ~sel_is_onehot(alu_sel_q);
        rsp_data_d  = alu_out;
        // Illegal selects fall through to default: zero data, flags untouched.
        case (alu_sel_q)
          OP_ADD, OP_SUB: begin
            flags_d[FLG_F] = alu_flcnz[FLG_F];
            flags_d[FLG_C] = alu_flcnz[FLG_C];
          end
          OP_CMP: begin
            rsp_data_d     = '0;
            flags_d[FLG_L] = alu_flcnz[FLG_L];
            flags_d[FLG_N] = alu_flcnz[FLG_N];
            flags_d[FLG_Z] = alu_flcnz[FLG_Z];
          end
          OP_AND, OP_OR, OP_XOR: begin
          end
          default: begin
            rsp_data_d = '0;
          end
        endcase
        alu_sel_d = '0;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed scoreboard bench for alu_req_arbiter with a stub ALU whose flags are programmed per step.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic              CLK;
  logic              RESET;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [SEL_W-1:0]  req0_sel, req1_sel;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic [FLAG_W-1:0] alu_flcnz;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [FLAG_W-1:0] flags;

  logic [FLAG_W-1:0] fl_stim;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] data;
    logic              err;
    logic [FLAG_W-1:0] flags;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  logic [FLAG_W-1:0] flags_m;
  logic rr_m;
  int n_vec;
  int n_err;
  int polls;
  int exp_port;

  alu_req_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_flcnz(alu_flcnz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .flags(flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stub ALU: real results for logic/arith, recognisable junk for CMP and illegal selects.
  always_comb begin
    case (alu_sel)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_CMP:  alu_out = 16'hDEAD;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      default: alu_out = 16'hBEEF;
    endcase
    alu_flcnz = fl_stim;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [SEL_W-1:0] sel,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [FLAG_W-1:0] fl);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (sel)
      6'b100000: begin e.data = a + b; flags_m[4] = fl[4]; flags_m[2] = fl[2]; end
      6'b010000: begin e.data = a - b; flags_m[4] = fl[4]; flags_m[2] = fl[2]; end
      6'b001000: begin e.data = '0; flags_m[3] = fl[3]; flags_m[1] = fl[1]; flags_m[0] = fl[0]; end
      6'b000100: e.data = a & b;
      6'b000010: e.data = a | b;
      6'b000001: e.data = a ^ b;
      default:   begin e.data = '0; e.err = 1'b1; end
    endcase
    e.flags = flags_m;
    sb.push_back(e);
  endtask

  // Present one request, wait for its grant, then drop valid and record the expectation.
  task automatic issue(input int port, input logic [SEL_W-1:0] sel,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [FLAG_W-1:0] fl);
    bit got;
    got = 0;
    fl_stim = fl;
    if (port == 0) begin
      req0_valid = 1'b1; req0_sel = sel; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_sel = sel; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      got = (port == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    push_exp(port[0], sel, a, b, fl);
  endtask

  task automatic wait_rsp(input string tag);
    exp_t e;
    polls = 0;
    while (polls < 20) begin
      @(negedge CLK);
      polls++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      chk({tag, "_id"},    {31'd0, rsp_id},    {31'd0, e.id});
      chk({tag, "_data"},  {16'd0, rsp_data},  {16'd0, e.data});
      chk({tag, "_err"},   {31'd0, rsp_err},   {31'd0, e.err});
      chk({tag, "_flags"}, {27'd0, flags},     {27'd0, e.flags});
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; flags_m = '0; rr_m = 1'b0;
    RESET = 1'b1; rsp_ready = 1'b1; fl_stim = '0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = '0; req1_sel = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    repeat (2) @(negedge CLK);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_flags",     {27'd0, flags},     32'd0);
    chk("rst_alu_sel",   {26'd0, alu_sel},   32'd0);
    chk("rst_rsp_data",  {16'd0, rsp_data},  32'd0);
    chk("rst_alu_a",     {16'd0, alu_a},     32'd0);
    #2 RESET = 1'b0;
    @(posedge CLK); #1;

    // Single ADD with carry-out and exact latency.
    issue(0, OP_ADD, 16'hFFFF, 16'h0001, 5'b00100);
    @(negedge CLK);
    chk("add_issue_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("add_issue_sel",    {26'd0, alu_sel},   {26'd0, OP_ADD});
    chk("add_issue_a",      {16'd0, alu_a},     32'h0000FFFF);
    wait_rsp("add");
    chk("add_latency", polls, 32'd1);
    chk("add_flags_abs", {27'd0, flags}, 32'b00100);
    @(posedge CLK); #1;

    // Both ports always valid: grant order alternates under round-robin.
    req0_valid = 1'b1; req0_sel = OP_ADD; req0_a = 16'h1000; req0_b = 16'h0234;
    req1_valid = 1'b1; req1_sel = OP_XOR; req1_a = 16'h00FF; req1_b = 16'h0F0F;
    fl_stim = 5'b10001;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = int'(rr_m);
`endif
      @(negedge CLK);
      chk("rr_ready0", {31'd0, req0_ready}, {31'd0, exp_port == 0});
      chk("rr_ready1", {31'd0, req1_ready}, {31'd0, exp_port == 1});
      @(posedge CLK); #1;
      if (exp_port == 0) push_exp(1'b0, OP_ADD, 16'h1000, 16'h0234, fl_stim);
      else               push_exp(1'b1, OP_XOR, 16'h00FF, 16'h0F0F, fl_stim);
      rr_m = (exp_port == 0);
      wait_rsp("rr");
      @(posedge CLK); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // CMP updates L/N/Z and returns zero; AND leaves flags alone.
    issue(0, OP_CMP, 16'h0005, 16'h0003, 5'b01011);
    wait_rsp("cmp");
    @(posedge CLK); #1;
    issue(1, OP_AND, 16'hF0F0, 16'h3C3C, 5'b11111);
    wait_rsp("and");
    @(posedge CLK); #1;

    // Back-pressure: response held, no grants while port 1 waits.
    rsp_ready = 1'b0;
    issue(0, OP_OR, 16'h1200, 16'h0034, 5'b11111);
    wait_rsp("bp");
    req1_valid = 1'b1; req1_sel = OP_XOR; req1_a = 16'hAAAA; req1_b = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_data",  {16'd0, rsp_data},  {16'd0, last_exp.data});
      chk("bp_hold_id",    {31'd0, rsp_id},    {31'd0, last_exp.id});
      chk("bp_no_ready",   {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("bp_released",   {31'd0, rsp_valid},  32'd0);
    chk("bp_idle_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge CLK); #1;
    req1_valid = 1'b0;
    push_exp(1'b1, OP_XOR, 16'hAAAA, 16'h5555, fl_stim);
    wait_rsp("bp_next");
    @(posedge CLK); #1;

    // Illegal select from port 1.
    issue(1, 6'b110000, 16'h1234, 16'h4321, 5'b10101);
    wait_rsp("illegal");
    @(posedge CLK); #1;

    // Reset while the operation sits in ISSUE.
    issue(0, OP_SUB, 16'h0010, 16'h0001, 5'b10100);
    void'(sb.pop_back());
    chk("rst_mid_sel", {26'd0, alu_sel}, {26'd0, OP_SUB});
    #1 RESET = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_flags", {27'd0, flags},     32'd0);
    chk("rst_mid_alu",   {26'd0, alu_sel},   32'd0);
    #1 RESET = 1'b0;
    flags_m = '0; rr_m = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge CLK); #1;

    // Normal service resumes after reset.
    issue(1, OP_XOR, 16'h0F0F, 16'h00FF, 5'b00000);
    wait_rsp("post_rst");
    @(posedge CLK); #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
